// File: rtl/aes_bus_sequencer_if.sv
// Host request/response handshake plus the byte-wide register bus to the AES core.
// master = sequencer side, slave = host/core side.
interface aes_bus_sequencer_if #(
  parameter int KEY_BYTES = 32,
  parameter int ADDR_W    = 7
);
  logic                   in_valid;
  logic                   in_ready;
  logic [127:0]           in_pt;
  logic [8*KEY_BYTES-1:0] in_key;
  logic                   in_key_reuse;
  logic                   out_valid;
  logic                   out_ready;
  logic [127:0]           out_ct;
  logic                   out_err;
  logic [ADDR_W-1:0]      ADDR;
  logic [7:0]             DIN;
  logic                   WR;
  logic                   START;
  logic                   OK;
  logic [7:0]             DOUT;

  modport master (
    input  in_valid, in_pt, in_key, in_key_reuse, out_ready, OK, DOUT,
    output in_ready, out_valid, out_ct, out_err, ADDR, DIN, WR, START
  );

  modport slave (
    output in_valid, in_pt, in_key, in_key_reuse, out_ready, OK, DOUT,
    input  in_ready, out_valid, out_ct, out_err, ADDR, DIN, WR, START
  );
endinterface

// File: rtl/aes_bus_sequencer.sv
// Sequences one AES block through a byte-wide core register bus: write pt/key/cfg/cmd,
// pulse START, wait for OK (with timeout), read back ct. Optional key cache: AES_SEQ_KEY_CACHE_EN.
module aes_bus_sequencer #(
  parameter int         KEY_BYTES = 32,
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] CFG_VAL   = 8'h01,
  parameter logic [7:0] CMD_VAL   = 8'h03,
  parameter int         TIMEOUT   = 1023
) (
  input  logic                 CLK,
  input  logic                 RST,
  aes_bus_sequencer_if.master  bus
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, WR_PT, WR_KEY, WR_CFG, WR_CMD, GO, WAIT_OK, RD_CT, RESP
  } state_t;

  state_t                 r_state, w_state_next;
  logic [5:0]             r_cnt;
  logic [TO_W-1:0]        r_to;
  logic [127:0]           r_pt;
  logic [8*KEY_BYTES-1:0] r_key;
  logic [127:0]           r_ct;
  logic                   r_err;
  logic [ADDR_W-1:0]      r_addr, w_addr;
  logic [7:0]             r_din, w_din;
  logic                   w_wr, w_start, w_skip_key;
  logic                   w_last_key, w_timeout;

  assign w_last_key = (r_state == WR_KEY) && (r_cnt == 6'(KEY_BYTES - 1));
  assign w_timeout  = (r_state == WAIT_OK) && !bus.OK && (r_to == TO_W'(TIMEOUT));

`ifdef AES_SEQ_KEY_CACHE_EN
  logic r_reuse, r_key_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_reuse     <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.in_valid) r_reuse <= bus.in_key_reuse;
      if (w_timeout)       r_key_valid <= 1'b0;
      else if (w_last_key) r_key_valid <= 1'b1;
    end
  end

  assign w_skip_key = r_reuse & r_key_valid;
`else
  logic w_unused_reuse;
  assign w_unused_reuse = bus.in_key_reuse;
  assign w_skip_key     = 1'b0;
`endif

  // Bus address/data default to the held register so they keep their last value.
  always_comb begin
    w_state_next = r_state;
    w_addr       = r_addr;
    w_din        = r_din;
    w_wr         = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_next = WR_PT;
      WR_PT: begin
        w_addr = ADDR_W'(r_cnt);
        w_din  = r_pt[7:0];
        w_wr   = 1'b1;
        if (r_cnt == 6'd15) w_state_next = w_skip_key ? WR_CFG : WR_KEY;
      end
      WR_KEY: begin
        w_addr = ADDR_W'(r_cnt) + ADDR_W'(32);
        w_din  = r_key[7:0];
        w_wr   = 1'b1;
        if (w_last_key) w_state_next = WR_CFG;
      end
      WR_CFG: begin
        w_addr       = ADDR_W'(64);
        w_din        = CFG_VAL;
        w_wr         = 1'b1;
        w_state_next = WR_CMD;
      end
      WR_CMD: begin
        w_addr       = ADDR_W'(65);
        w_din        = CMD_VAL;
        w_wr         = 1'b1;
        w_state_next = GO;
      end
      GO: begin
        w_start      = 1'b1;
        w_state_next = WAIT_OK;
      end
      WAIT_OK: begin
        if (bus.OK)         w_state_next = RD_CT;
        else if (w_timeout) w_state_next = RESP;
      end
      RD_CT: begin
        if (r_cnt < 6'd16) w_addr = ADDR_W'(r_cnt) + ADDR_W'(16);
        if (r_cnt == 6'd16) w_state_next = RESP;
      end
      RESP:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_to    <= '0;
      r_pt    <= '0;
      r_key   <= '0;
      r_ct    <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr;
      r_din   <= w_din;
      r_cnt   <= (w_state_next != r_state) ? 6'd0 : r_cnt + 6'd1;
      if (r_state != WAIT_OK)            r_to <= '0;
      else if (r_to != TO_W'(TIMEOUT))   r_to <= r_to + TO_W'(1);
      // pt/key are shifted out LSB-first; ct is shifted in so byte 0 lands lowest.
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_pt  <= bus.in_pt;
          r_key <= bus.in_key;
        end
        WR_PT:   r_pt  <= r_pt >> 8;
        WR_KEY:  r_key <= r_key >> 8;
        WAIT_OK: if (w_timeout) begin
          r_ct  <= '0;
          r_err <= 1'b1;
        end
        RD_CT: if (r_cnt != 6'd0) begin
          r_ct  <= {bus.DOUT, r_ct[127:8]};
          r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == RESP);
  assign bus.out_ct    = r_ct;
  assign bus.out_err   = r_err;
  assign bus.ADDR      = w_addr;
  assign bus.DIN       = w_din;
  assign bus.WR        = w_wr;
  assign bus.START     = w_start;
endmodule

// File: tb/tb_aes_bus_sequencer.sv
// Scoreboard bench for aes_bus_sequencer: main instance with a responsive core model,
// second instance (TIMEOUT=15) whose core never raises OK.
module tb_aes_bus_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_bus_sequencer_if #(.KEY_BYTES(32), .ADDR_W(7)) b();
  aes_bus_sequencer_if #(.KEY_BYTES(32), .ADDR_W(7)) bt();

  aes_bus_sequencer #(.KEY_BYTES(32), .ADDR_W(7), .CFG_VAL(8'h01), .CMD_VAL(8'h03), .TIMEOUT(1023))
    dut (.CLK(clk), .RST(rst), .bus(b));
  aes_bus_sequencer #(.KEY_BYTES(32), .ADDR_W(7), .CFG_VAL(8'h01), .CMD_VAL(8'h03), .TIMEOUT(15))
    dut_to (.CLK(clk), .RST(rst), .bus(bt));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: registered read data, OK raised 20 cycles after START.
  int ok_dly;
  always @(posedge clk) begin
    if (rst) begin
      b.OK   <= 1'b0;
      b.DOUT <= 8'h00;
      ok_dly <= 0;
    end else begin
      b.DOUT <= (b.ADDR >= 7'd16 && b.ADDR < 7'd32) ? 8'hA0 + {1'b0, b.ADDR - 7'd16} : 8'h00;
      if (b.START) begin
        b.OK   <= 1'b0;
        ok_dly <= 1;
      end else if (ok_dly != 0) begin
        if (ok_dly == 19) begin
          b.OK   <= 1'b1;
          ok_dly <= 0;
        end else ok_dly <= ok_dly + 1;
      end
    end
  end

  assign bt.OK        = 1'b0;
  assign bt.DOUT      = 8'h00;
  assign bt.out_ready = 1'b1;

  logic [14:0]  wlog[$];
  int           start_cnt = 0;
  logic [128:0] exp_q[$];
  logic [128:0] exp_tq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (b.WR) wlog.push_back({b.ADDR, b.DIN});
      if (b.START) start_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst && b.out_valid && b.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got err=%0b ct=%032h required none", b.out_err, b.out_ct);
      end else begin
        checks--;
        $display("txn main: err=%0b ct=%032h", b.out_err, b.out_ct);
        chk("main_result", {b.out_err, b.out_ct}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bt.out_valid && bt.out_ready) begin
      checks++;
      if (exp_tq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_to_result: got err=%0b ct=%032h required none", bt.out_err, bt.out_ct);
      end else begin
        checks--;
        $display("txn timeout: err=%0b ct=%032h", bt.out_err, bt.out_ct);
        chk("timeout_result", {bt.out_err, bt.out_ct}, exp_tq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [127:0] pt, input logic [255:0] key, input logic reuse);
    int n = 0;
    while (!b.in_ready && n < 500) begin
      tick();
      n++;
    end
    chk("in_ready_wait", b.in_ready, 1);
    b.in_valid     = 1'b1;
    b.in_pt        = pt;
    b.in_key       = key;
    b.in_key_reuse = reuse;
    tick();
    b.in_valid     = 1'b0;
    $display("txn issue: pt=%032h reuse=%0b", pt, reuse);
  endtask

  task automatic wait_out(input int budget);
    int n = 0;
    while (!b.out_valid && n < budget) begin
      tick();
      n++;
    end
    chk("out_valid_wait", b.out_valid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!b.in_ready && n < 50) begin
      tick();
      n++;
    end
  endtask

  function automatic int count_key_writes();
    int c = 0;
    foreach (wlog[i]) if (wlog[i][14:8] >= 7'd32 && wlog[i][14:8] < 7'd64) c++;
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] pt1, pt2, exp_ct;
    logic [255:0] key1;
    logic [14:0]  ew;
    int           n;
    pt1  = 128'h1234567890ABCDEF01234567899ABCDE;
    pt2  = 128'h00112233445566778899AABBCCDDEEFF;
    key1 = 256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;
    for (int k = 0; k < 16; k++) exp_ct[8*k +: 8] = 8'hA0 + 8'(k);

    b.in_valid = 1'b0; b.in_pt = '0; b.in_key = '0; b.in_key_reuse = 1'b0; b.out_ready = 1'b1;
    bt.in_valid = 1'b0; bt.in_pt = '0; bt.in_key = '0; bt.in_key_reuse = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", b.in_ready, 1);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_out_err", b.out_err, 0);
    chk("rst_out_ct", b.out_ct, 0);
    chk("rst_addr", b.ADDR, 0);
    chk("rst_din", b.DIN, 0);
    chk("rst_wr", b.WR, 0);
    chk("rst_start", b.START, 0);
    rst = 1'b0;
    tick();

    // Full transaction, result held with out_ready low for 10 cycles.
    wlog.delete(); start_cnt = 0; b.out_ready = 1'b0;
    issue(pt1, key1, 1'b0);
    exp_q.push_back({1'b0, exp_ct});
    wait_out(400);
    chk("t1_write_count", wlog.size(), 50);
    chk("t1_start_count", start_cnt, 1);
    for (int i = 0; i < 50; i++) begin
      if (i < 16)      ew = {7'(i), pt1[8*i +: 8]};
      else if (i < 48) ew = {7'(i + 16), key1[8*(i-16) +: 8]};
      else if (i == 48) ew = {7'd64, 8'h01};
      else             ew = {7'd65, 8'h03};
      if (i < wlog.size()) chk($sformatf("t1_write_%0d", i), wlog[i], ew);
    end
    repeat (10) begin
      chk("hold_in_ready", b.in_ready, 0);
      chk("hold_out_valid", b.out_valid, 1);
      chk("hold_out_ct", b.out_ct, exp_ct);
      tick();
    end
    b.out_ready = 1'b1;
    tick();
    wlog.delete(); start_cnt = 0;

    // Back-to-back request asking to reuse the key.
    issue(pt2, key1, 1'b1);
    exp_q.push_back({1'b0, exp_ct});
    wait_out(400);
`ifdef AES_SEQ_KEY_CACHE_EN
    chk("t2_write_count", wlog.size(), 18);
    chk("t2_key_writes", count_key_writes(), 0);
`else
    chk("t2_write_count", wlog.size(), 50);
    chk("t2_key_writes", count_key_writes(), 32);
`endif
    if (wlog.size() >= 2) begin
      chk("t2_cfg_write", wlog[wlog.size()-2], {7'd64, 8'h01});
      chk("t2_cmd_write", wlog[wlog.size()-1], {7'd65, 8'h03});
    end
    chk("t2_start_count", start_cnt, 1);
    wait_idle();

    // Reset in the middle of the key writes.
    wlog.delete();
    issue(pt1, key1, 1'b0);
    n = 0;
    while (!(b.WR && b.ADDR == 7'd37) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_wr_key", b.ADDR, 37);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_wr", b.WR, 0);
    chk("midrst_in_ready", b.in_ready, 1);
    chk("midrst_addr", b.ADDR, 0);
    chk("midrst_start", b.START, 0);
    repeat (2) tick();
    rst = 1'b0;
    wlog.delete(); start_cnt = 0;

    // Reset cleared the key cache, so reuse must still write the key.
    issue(pt2, key1, 1'b1);
    exp_q.push_back({1'b0, exp_ct});
    wait_out(400);
    chk("t4_write_count", wlog.size(), 50);
    if (wlog.size() > 0) chk("t4_first_addr", wlog[0][14:8], 0);
    chk("t4_key_writes", count_key_writes(), 32);
    wait_idle();

    // Timeout instance: OK never rises.
    bt.in_valid = 1'b1; bt.in_pt = pt1; bt.in_key = key1;
    tick();
    bt.in_valid = 1'b0;
    exp_tq.push_back({1'b1, 128'h0});
    $display("txn issue timeout: pt=%032h", pt1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bt.START && n < 200);
    chk("to_start_seen", bt.START, 1);
    n = 0;
    while (!bt.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", n, 17);
    repeat (3) tick();

    chk("main_queue_drained", exp_q.size(), 0);
    chk("to_queue_drained", exp_tq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_bus_sequencer.md
AES_BUS_SEQUENCER -- requirements
Module: aes_bus_sequencer

Interface
REQ-001 Parameter KEY_BYTES, 32, cipher-key length in bytes; legal values 16, 24, 32.
REQ-002 Parameter ADDR_W, 7, width of the core register-bus address.
REQ-003 Parameter CFG_VAL, 8'h01, byte written to the config register, addr 64.
REQ-004 Parameter CMD_VAL, 8'h03, byte written to the command register, addr 65.
REQ-005 Parameter TIMEOUT, 1023, maximum cycles to wait for OK before aborting.
REQ-006 CLK  in  1  sole clock; all logic on the rising edge.
REQ-007 RST  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  host request valid.
REQ-009 in_ready  out  1  sequencer can accept a request.
REQ-010 in_pt  in  128  plaintext.
REQ-011 in_key  in  8*KEY_BYTES  cipher key.
REQ-012 in_key_reuse  in  1  skip the key write for this request; honoured only when the cache feature is compiled in.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  host accepts the result.
REQ-015 out_ct  out  128  ciphertext.
REQ-016 out_err  out  1  result aborted by timeout; valid only with out_valid.
REQ-017 ADDR  out  ADDR_W  core bus address.
REQ-018 DIN  out  8  core write data.
REQ-019 WR  out  1  core write strobe; 0 means a read.
REQ-020 START  out  1  one-cycle start pulse to the core.
REQ-021 OK  in  1  core done flag, level.
REQ-022 DOUT  in  8  core read data; valid one cycle after ADDR is presented with WR=0.

Function
REQ-023 States SHALL be: IDLE, WR_PT, WR_KEY, WR_CFG, WR_CMD, GO, WAIT_OK, RD_CT, RESP.
REQ-024 in_ready SHALL be 1 only in IDLE; in IDLE, in_valid=1 captures in_pt, in_key and in_key_reuse and moves to WR_PT.
REQ-025 WR_PT SHALL take 16 cycles; cycle k drives ADDR=k, DIN=in_pt[8k+7:8k], WR=1.
REQ-026 WR_KEY SHALL take KEY_BYTES cycles; cycle k drives ADDR=32+k, DIN=key[8k+7:8k], WR=1.
REQ-027 WR_CFG SHALL take 1 cycle: ADDR=64, DIN=CFG_VAL, WR=1. WR_CMD SHALL take 1 cycle: ADDR=65, DIN=CMD_VAL, WR=1.
REQ-028 GO SHALL take 1 cycle: START=1, WR=0. START SHALL be 0 in every other state.
REQ-029 WAIT_OK SHALL hold WR=0 and count cycles; OK=1 moves to RD_CT; count reaching TIMEOUT moves to RESP with out_err=1 and out_ct=0.
REQ-030 RD_CT SHALL drive ADDR=16+k, WR=0 for k=0..15 and capture DOUT one cycle later into out_ct[8k+7:8k]; the state lasts 17 cycles.
REQ-031 RESP SHALL assert out_valid; out_ct and out_err SHALL stay stable until out_ready=1; the handshake cycle returns to IDLE.
REQ-032 Outside the write states WR SHALL be 0; ADDR and DIN keep their last values.
REQ-033 in_valid SHALL be ignored outside IDLE; back-to-back requests are accepted in the cycle after a RESP handshake.
REQ-034 OK already high on entry to WAIT_OK SHALL be accepted on the first WAIT_OK cycle.
REQ-035 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits wide, clear on entry to WAIT_OK, and not wrap.

Reset
REQ-036 RST=1 SHALL immediately force IDLE with in_ready=1, out_valid=0, out_err=0, out_ct=0, ADDR=0, DIN=0, WR=0, START=0, counters=0, and clear the key-cache valid flag; this holds mid-transaction.

Configuration
REQ-037 Macro AES_SEQ_KEY_CACHE_EN defined: a key-valid flag sets after any WR_KEY completes; a request with in_key_reuse=1 and the flag set goes from WR_PT straight to WR_CFG. A timeout clears the flag.
REQ-038 Macro AES_SEQ_KEY_CACHE_EN undefined: in_key_reuse SHALL be ignored and WR_KEY always runs.

Verification
REQ-039 Reset, then in_pt=128'h1234567890ABCDEF01234567899ABCDE with a 256-bit key -> exactly 16+32+2 WR=1 cycles, bytes in REQ-025/026 order, then a single START pulse.
REQ-040 Core model raises OK 20 cycles after START and returns DOUT=8'hA0+k for addr 16+k -> out_ct byte k = 8'hA0+k, out_err=0.
REQ-041 OK never rises with TIMEOUT=15 -> out_valid with out_err=1 and out_ct=0 exactly 16 cycles after the first WAIT_OK cycle.
REQ-042 Hold out_ready=0 for 10 cycles in RESP -> out_ct stable and in_ready=0 throughout.
REQ-043 Assert RST during WR_KEY -> WR=0 and in_ready=1 with no clock edge; a fresh request restarts at ADDR=0.
REQ-044 With AES_SEQ_KEY_CACHE_EN defined, a second request with in_key_reuse=1 -> 18 write cycles, no addr 32..63 writes. Without the macro -> 50 write cycles.
